// File: rtl/gf2_poly_div_seq.sv
// gf2_poly_div_seq: sequential carry-less (GF(2)) polynomial long divider.
// Given dividend C and divisor B, produces Q and R with C = Q*B ^ R and
// deg(R) < deg(B). One division step is retired per clock. Operands are
// taken over a valid/ready input handshake, and results are returned over a
// valid/ready output handshake.
module gf2_poly_div_seq #(
    parameter int M = 5,
    parameter int N = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] C,
    input  logic [M-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Q,
    output logic [M-2:0] R,
    output logic         div_zero
);

    localparam int D_W   = (M > 1) ? $clog2(M) : 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [N-1:0]       dvd_q;      // dividend, shifted out MSB first
    logic [M-2:0]       b_q;        // divisor without its top bit (see below)
    logic [D_W-1:0]     d_q;        // degree of the divisor
    logic [M-2:0]       r_q;        // working remainder, deg < d
    logic [N-1:0]       q_q;        // quotient being assembled
    logic [CNT_W-1:0]   cnt_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [N-1:0]       Q_q;
    logic [M-2:0]       R_q;
    logic               dz_q;

    logic [M-1:0]       r_shift;
    logic               qbit;
    logic [M-2:0]       r_d;
    logic [N-1:0]       q_d;
    logic [D_W-1:0]     d_d;

    // Priority encoder: index of the highest set bit (0 when v is zero).
    function automatic logic [D_W-1:0] msb_index(input logic [M-1:0] v);
        logic [D_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < M; i++) begin
            if (v[i]) idx = D_W'(i);
        end
        return idx;
    endfunction

    // One long-division step. r' = (r<<1)|next bit. When r'[d] is set the
    // divisor is subtracted (XORed). The result always has bit M-1 clear,
    // since either r' stayed below degree d or bit d was cancelled. Only the
    // low M-1 bits of the remainder and of the divisor therefore take part
    // in the XOR.
    always_comb begin
        r_shift = {r_q, dvd_q[N-1]};
        qbit    = r_shift[d_q];
        r_d     = r_shift[M-2:0] ^ (qbit ? b_q : '0);
        q_d     = {q_q[N-2:0], qbit};
        d_d     = msb_index(B);
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dvd_q       <= '0;
            b_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            Q_q         <= '0;
            R_q         <= '0;
            dz_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dvd_q      <= C;
                        b_q        <= B[M-2:0];
                        d_q        <= d_d;
                        r_q        <= '0;
                        q_q        <= '0;
                        in_ready_q <= 1'b0;
                        if (B == '0) begin
                            // Division by zero: report immediately.
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            dz_q        <= 1'b1;
                            Q_q         <= '0;
                            R_q         <= '0;
                        end else begin
                            state_q <= CALC;
                            cnt_q   <= CNT_W'(N - 1);
                            dz_q    <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    dvd_q <= {dvd_q[N-2:0], 1'b0};
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        // Last of the N steps: publish the result.
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        Q_q         <= q_d;
                        R_q         <= r_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Q         = Q_q;
    assign R         = R_q;
    assign div_zero  = dz_q;

endmodule

// File: doc/gf2_poly_div_seq.md
Name: gf2_poly_div_seq

Overview:
- Sequential carry-less (GF(2)) polynomial divider. It is the inverse companion to the team's combinational Karatsuba GF(2) multipliers.
- Takes an N-bit product polynomial C and an M-bit divisor B, and returns quotient Q and remainder R such that C = Q·B XOR R, with deg(R) < deg(B).
- Used to check multiplier output and to perform field reduction.
- Performs one long-division step per clock, with valid/ready handshakes on both sides.

Parameters:
- M, 5, divisor width in bits. The divisor may have degree 0..M-1.
- N, 9, dividend width in bits (2M-1 matches the multiplier output width).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  C and B are valid.
- in_ready  output  1  block can accept an operand pair.
- C  input  N  dividend polynomial; bit i is the coefficient of x^i.
- B  input  M  divisor polynomial.
- out_valid  output  1  Q, R and div_zero are valid.
- out_ready  input  1  consumer accepts the result.
- Q  output  N  quotient, zero-extended.
- R  output  M-1  remainder, zero-extended.
- div_zero  output  1  set when B was 0.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; in_ready=1; out_valid=0.
  - Q, R, div_zero, step counter and internal registers all 0.
- States are IDLE, CALC and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready (accept edge): latch C into a dividend shift register and latch B.
  - Compute d = index of the highest set bit of B with a priority encoder; latch d.
  - Clear the working remainder r (M bits) and quotient q.
  - If B==0: go to DONE with div_zero=1, Q=0, R=0.
  - Otherwise: go to CALC with counter=N-1.
- CALC, per edge (in_ready=0):
  - r' = (r<<1) | next dividend bit, taken MSB first (C[N-1] on the first step). r' fits in M bits because deg(r) < d ≤ M-1.
  - If r'[d]==1: r = r' XOR B and qbit=1. Otherwise: r = r' and qbit=0.
  - q = (q<<1) | qbit.
  - Counter decrements. The step that executes with counter==0 is the last; go to DONE.
  - Exactly N iteration edges.
- DONE:
  - out_valid=1; Q=q; R=r[M-2:0] (bits at or above d are always 0).
  - Outputs stay stable while out_ready=0.
  - On out_valid&out_ready: go to IDLE, out_valid=0.
  - in_ready stays 0 in DONE. Back-to-back throughput is therefore one operation per N+2 cycles; div-by-zero takes 2 cycles.
- Latency: accept edge at edge 0, so out_valid is high after edge N (div-by-zero: after edge 1).
- The divisor of degree 0 (B=1) is legal: Q=C, R=0.
- in_valid while in_ready=0 is ignored. C and B are sampled only on the accept edge, so later changes to them have no effect.
- rst_n asserted mid-CALC or in DONE: immediate return to the reset values; the in-flight result is discarded and out_valid is never raised for it.
- All arithmetic is XOR only; there are no carries.

Test Plan:
- Reset then idle: rst_n low for 2 cycles -> in_ready=1, out_valid=0, Q=0, R=0, div_zero=0.
- Exact division: C=9'h079, B=5'b00111 -> out_valid after 9 edges; Q=9'h013, R=4'h0, div_zero=0.
- Nonzero remainder: C=9'h1FF, B=5'b10011 -> Q=9'h01D, R=4'b1000.
- Degree-0 divisor and back-to-back: C=9'h155, B=5'b00001 with out_ready=1 -> Q=9'h155, R=0.
  - Then immediately present C=9'h079, B=5'b00111 -> accepted on the first IDLE cycle; Q=9'h013.
- Divide by zero plus backpressure: B=0, C=9'h0AA, out_ready=0 for 3 cycles -> out_valid=1 from edge 1, div_zero=1, Q=0, R=0.
  - Outputs and in_ready=0 hold until out_ready=1, then the block returns to IDLE.
- Reset mid-operation: start C=9'h1FF, B=5'b10011; assert rst_n low at iteration 4 -> outputs reset asynchronously.
  - After release, a new operation C=9'h079, B=5'b00111 gives Q=9'h013, R=0.
